// File: rtl/map_pkg.sv
// map_pkg: shared map geometry, sprite codes, requester indices and the
// tile-address helper used by the map arbiter.
package map_pkg;

  localparam int MAP_W     = 21;
  localparam int MAP_H     = 23;
  localparam int MAP_CELLS = MAP_W * MAP_H;
  localparam int NREQ      = 3;

  typedef logic [2:0] sprite_t;

  localparam sprite_t SPR_EMPTY  = 3'd0;
  localparam sprite_t SPR_PELLET = 3'd1;
  localparam sprite_t SPR_WALL   = 3'd2;
  localparam sprite_t SPR_POWER  = 3'd3;
  localparam sprite_t SPR_PLAYER = 3'd4;
  localparam sprite_t SPR_GHOST  = 3'd5;

  localparam sprite_t INIT_SPRITE = SPR_PELLET;

  localparam int REQ_RENDER = 0;
  localparam int REQ_PLAYER = 1;
  localparam int REQ_GHOST  = 2;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_INIT = 2'd1,
    ST_RUN  = 2'd2
  } init_state_t;

  // Row-major tile address, truncated to the 9-bit RAM address space.
  function automatic logic [8:0] cell_addr(input logic [4:0] x, input logic [4:0] y,
                                           input int w);
    cell_addr = 9'(int'(y) * w + int'(x));
  endfunction

endpackage

// File: rtl/map_arbiter_rr_pick.sv
// rr_pick: one-hot round-robin selection, searching upward from ptr and
// wrapping past the last requester.
module rr_pick #(
  parameter int NREQ = 3,
  parameter int PW   = 2
) (
  input  logic [NREQ-1:0] req,
  input  logic [PW-1:0]   ptr,
  output logic [NREQ-1:0] grant,
  output logic            valid
);

  // First active request at or after ptr wins.
  always_comb begin
    grant = '0;
    valid = 1'b0;
    for (int k = 0; k < NREQ; k++) begin
      int            idx;
      logic [PW-1:0] sel;
      idx = int'(ptr) + k;
      if (idx >= NREQ) idx = idx - NREQ;
      sel = PW'(idx);
      if (!valid && req[sel]) begin
        grant[sel] = 1'b1;
        valid      = 1'b1;
      end
    end
  end

endmodule

// File: rtl/map_arbiter.sv
// map_arbiter: round-robin arbiter sharing the single-port tile-map RAM
// between renderer (0), player (1) and ghosts (2). One access per cycle,
// reads return two cycles after the request is sampled.
// Build macro MAP_ARB_INIT_EN: after reset, fill every cell with INIT_SPRITE
// before arbitration starts.
module map_arbiter #(
  parameter int MAP_W = map_pkg::MAP_W,
  parameter int MAP_H = map_pkg::MAP_H,
  parameter int NREQ  = map_pkg::NREQ
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [NREQ-1:0]   req,
  input  logic [NREQ-1:0]   req_we,
  input  logic [NREQ*5-1:0] req_x,
  input  logic [NREQ*5-1:0] req_y,
  input  logic [NREQ*3-1:0] req_wdata,
  output logic [NREQ-1:0]   gnt,
  output logic [NREQ-1:0]   rvalid,
  output logic [2:0]        rdata,
  output logic [NREQ-1:0]   err,
  output logic [8:0]        mem_addr,
  output logic [2:0]        mem_wdata,
  output logic              mem_we,
  input  logic [2:0]        mem_q,
  output logic              init_busy
);
  import map_pkg::sprite_t;
  import map_pkg::INIT_SPRITE;
  import map_pkg::cell_addr;

  localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;

  logic [PW-1:0]   ptr, ptr_nx;
  logic [NREQ-1:0] cand, pick;
  logic            pick_vld, arb_en;
  logic [4:0]      sel_x, sel_y;
  logic            sel_we, oob;
  sprite_t         sel_wd;
  logic [8:0]      addr_p0;
  logic [NREQ-1:0] rd_p1, rv_p2;
  logic            init_wr;
  logic [8:0]      init_addr;

`ifdef MAP_ARB_INIT_EN
  import map_pkg::init_state_t;
  import map_pkg::ST_IDLE;
  import map_pkg::ST_INIT;
  import map_pkg::ST_RUN;

  localparam int CELLS = MAP_W * MAP_H;

  init_state_t state, state_nx;
  logic [8:0]  cnt, cnt_nx;
  logic        init_wr_q;

  // Init FSM state, fill counter, and marker that the RAM port shows an init write.
  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= ST_IDLE;
      cnt       <= '0;
      init_wr_q <= 1'b0;
    end else begin
      state     <= state_nx;
      cnt       <= cnt_nx;
      init_wr_q <= init_wr;
    end
  end

  // Issue one fill write per cycle from address 0 up to the last cell.
  always_comb begin
    state_nx = state;
    cnt_nx   = cnt;
    init_wr  = 1'b0;
    case (state)
      ST_IDLE: begin
        init_wr  = 1'b1;
        cnt_nx   = 9'd1;
        state_nx = (CELLS == 1) ? ST_RUN : ST_INIT;
      end
      ST_INIT: begin
        init_wr = 1'b1;
        cnt_nx  = cnt + 9'd1;
        if (cnt == 9'(CELLS - 1)) state_nx = ST_RUN;
      end
      ST_RUN:  state_nx = ST_RUN;
      default: state_nx = ST_IDLE;
    endcase
  end

  assign init_addr = cnt;
  // Busy stays high through the cycle the final fill write is on the port.
  assign init_busy = (state != ST_RUN) || init_wr_q;
`else
  assign init_wr   = 1'b0;
  assign init_addr = '0;
  assign init_busy = 1'b0;
`endif

  assign arb_en = ~init_busy;
  assign cand   = req & ~gnt & {NREQ{arb_en}};

  rr_pick #(.NREQ(NREQ), .PW(PW)) u_rr_pick (
    .req  (cand),
    .ptr  (ptr),
    .grant(pick),
    .valid(pick_vld)
  );

  // Route the winner's fields, check range, and compute the next pointer.
  always_comb begin
    sel_x  = '0;
    sel_y  = '0;
    sel_we = 1'b0;
    sel_wd = '0;
    ptr_nx = ptr;
    for (int i = 0; i < NREQ; i++) begin
      if (pick[i]) begin
        sel_x  = req_x[i*5 +: 5];
        sel_y  = req_y[i*5 +: 5];
        sel_we = req_we[i];
        sel_wd = req_wdata[i*3 +: 3];
        ptr_nx = (i == NREQ - 1) ? '0 : PW'(i + 1);
      end
    end
    oob     = (int'(sel_x) >= MAP_W) || (int'(sel_y) >= MAP_H);
    addr_p0 = cell_addr(sel_x, sel_y, MAP_W);
  end

  // p0 -> p1: register the decision onto the RAM port; p1 -> p2: read return.
  always_ff @(posedge clk) begin
    if (reset) begin
      gnt       <= '0;
      err       <= '0;
      rd_p1     <= '0;
      rv_p2     <= '0;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      ptr       <= '0;
    end else begin
      rv_p2 <= rd_p1;
      if (init_wr) begin
        gnt       <= '0;
        err       <= '0;
        rd_p1     <= '0;
        mem_we    <= 1'b1;
        mem_addr  <= init_addr;
        mem_wdata <= INIT_SPRITE;
      end else if (pick_vld) begin
        gnt <= pick;
        ptr <= ptr_nx;
        if (oob) begin
          err    <= pick;
          rd_p1  <= '0;
          mem_we <= 1'b0;
        end else begin
          err       <= '0;
          rd_p1     <= sel_we ? '0 : pick;
          mem_we    <= sel_we;
          mem_addr  <= addr_p0;
          mem_wdata <= sel_wd;
        end
      end else begin
        gnt    <= '0;
        err    <= '0;
        rd_p1  <= '0;
        mem_we <= 1'b0;
      end
    end
  end

  // A read in flight when reset arrives never reports valid data.
  assign rvalid = rv_p2 & {NREQ{~reset}};
  assign rdata  = (|rvalid) ? mem_q : 3'd0;

endmodule

// File: tb/tb_map_arbiter.sv
// tb_map_arbiter: table-driven single-access vectors plus hand-written
// sequences for contention, reset during a read, and optional map fill.
module tb_map_arbiter;

  logic        clk = 1'b0;
  logic        reset;
  logic [2:0]  req, req_we;
  logic [14:0] req_x, req_y;
  logic [8:0]  req_wdata;
  logic [2:0]  gnt, rvalid, rdata, err, mem_wdata, mem_q;
  logic [8:0]  mem_addr;
  logic        mem_we, init_busy;

  logic [2:0]  ram [512];
  int          n_chk = 0;
  int          n_fail = 0;
  logic [8:0]  last_addr;

  typedef struct {
    int         idx;
    logic       we;
    logic [4:0] x;
    logic [4:0] y;
    logic [2:0] wd;
    logic [8:0] e_addr;
    logic       e_err;
    logic [2:0] e_rdata;
  } vec_t;

  vec_t vecs [13];

  always #5 clk = ~clk;

  map_arbiter dut (
    .clk      (clk),
    .reset    (reset),
    .req      (req),
    .req_we   (req_we),
    .req_x    (req_x),
    .req_y    (req_y),
    .req_wdata(req_wdata),
    .gnt      (gnt),
    .rvalid   (rvalid),
    .rdata    (rdata),
    .err      (err),
    .mem_addr (mem_addr),
    .mem_wdata(mem_wdata),
    .mem_we   (mem_we),
    .mem_q    (mem_q),
    .init_busy(init_busy)
  );

  // Single-port RAM model with registered address.
  always @(posedge clk) begin
    if (mem_we) ram[mem_addr] <= mem_wdata;
    mem_q <= ram[mem_addr];
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic clear_req();
    req = '0; req_we = '0; req_x = '0; req_y = '0; req_wdata = '0;
  endtask

  task automatic drive_one(input int idx, input logic we, input logic [4:0] x,
                           input logic [4:0] y, input logic [2:0] wd);
    clear_req();
    req[idx]             = 1'b1;
    req_we[idx]          = we;
    req_x[idx*5 +: 5]    = x;
    req_y[idx*5 +: 5]    = y;
    req_wdata[idx*3 +: 3] = wd;
  endtask

  task automatic check_zero(input string tag);
    chk({tag, "_gnt"}, gnt, 0);
    chk({tag, "_rvalid"}, rvalid, 0);
    chk({tag, "_err"}, err, 0);
    chk({tag, "_mem_we"}, mem_we, 0);
    chk({tag, "_mem_addr"}, mem_addr, 0);
    chk({tag, "_mem_wdata"}, mem_wdata, 0);
    chk({tag, "_rdata"}, rdata, 0);
  endtask

  // Follow the map fill (if built in) until init_busy drops.
  task automatic wait_init();
`ifdef MAP_ARB_INIT_EN
    int wr;
    int cyc;
    bit ok;
    wr = 0; cyc = 0; ok = 1'b1;
    while (init_busy && cyc < 1000) begin
      if (mem_we) begin
        if (mem_addr != 9'(wr) || mem_wdata != 3'd1) ok = 1'b0;
        wr++;
      end
      if (gnt != 0 || rvalid != 0 || err != 0) ok = 1'b0;
      @(posedge clk); #1;
      cyc++;
    end
    chk("init_done", init_busy, 0);
    chk("init_writes", wr, 483);
    chk("init_seq", ok, 1);
    chk("init_idle_we", mem_we, 0);
`endif
  endtask

  task automatic do_reset();
    clear_req();
    reset = 1'b1;
    @(posedge clk); #1;
    @(posedge clk); #1;
    reset = 1'b0;
    wait_init();
  endtask

  task automatic run_vec(input int n, input vec_t v);
    logic [2:0] oh;
    logic       e_rd;
    string      t;
    t  = $sformatf("v%0d", n);
    oh = 3'b001 << v.idx;
    e_rd = !v.we && !v.e_err;
    drive_one(v.idx, v.we, v.x, v.y, v.wd);
    @(posedge clk); #1;
    chk({t, "_gnt"}, gnt, oh);
    chk({t, "_err"}, err, v.e_err ? oh : 3'd0);
    chk({t, "_mem_we"}, mem_we, v.we && !v.e_err);
    if (!v.e_err) begin
      chk({t, "_mem_addr"}, mem_addr, v.e_addr);
      last_addr = v.e_addr;
    end
    if (v.we && !v.e_err) chk({t, "_mem_wdata"}, mem_wdata, v.wd);
    chk({t, "_rvalid_early"}, rvalid, 0);
    chk({t, "_rdata_idle"}, rdata, 0);
    clear_req();
    @(posedge clk); #1;
    chk({t, "_rvalid"}, rvalid, e_rd ? oh : 3'd0);
    chk({t, "_rdata"}, rdata, e_rd ? v.e_rdata : 3'd0);
    chk({t, "_gnt_drop"}, gnt, 0);
    chk({t, "_we_idle"}, mem_we, 0);
    if (!v.e_err) chk({t, "_addr_hold"}, mem_addr, last_addr);
  endtask

  initial begin
    logic [8:0] caddr [3];
    int         g;

    //          idx we  x      y      wd     addr     err   rdata
    vecs[0]  = '{2, 1'b1, 5'd20, 5'd22, 3'd4, 9'd482, 1'b0, 3'd0};
    vecs[1]  = '{1, 1'b1, 5'd3,  5'd2,  3'd6, 9'd45,  1'b0, 3'd0};
    vecs[2]  = '{1, 1'b0, 5'd3,  5'd2,  3'd0, 9'd45,  1'b0, 3'd6};
    vecs[3]  = '{0, 1'b0, 5'd21, 5'd0,  3'd0, 9'd0,   1'b1, 3'd0};
    vecs[4]  = '{0, 1'b0, 5'd20, 5'd22, 3'd0, 9'd482, 1'b0, 3'd4};
    vecs[5]  = '{2, 1'b0, 5'd0,  5'd23, 3'd0, 9'd0,   1'b1, 3'd0};
    vecs[6]  = '{0, 1'b1, 5'd0,  5'd0,  3'd3, 9'd0,   1'b0, 3'd0};
    vecs[7]  = '{2, 1'b0, 5'd0,  5'd0,  3'd0, 9'd0,   1'b0, 3'd3};
    vecs[8]  = '{1, 1'b1, 5'd31, 5'd31, 3'd7, 9'd0,   1'b1, 3'd0};
    vecs[9]  = '{0, 1'b1, 5'd0,  5'd1,  3'd5, 9'd21,  1'b0, 3'd0};
    vecs[10] = '{1, 1'b0, 5'd0,  5'd1,  3'd0, 9'd21,  1'b0, 3'd5};
    vecs[11] = '{2, 1'b1, 5'd20, 5'd0,  3'd2, 9'd20,  1'b0, 3'd0};
    vecs[12] = '{0, 1'b0, 5'd20, 5'd0,  3'd0, 9'd20,  1'b0, 3'd2};
    caddr[0] = 9'd1; caddr[1] = 9'd23; caddr[2] = 9'd68;
    last_addr = '0;

    // Reset state, with a player read pending across reset release.
    reset = 1'b1;
    drive_one(1, 1'b0, 5'd3, 5'd2, 3'd0);
    @(posedge clk); #1;
    check_zero("rst");
    @(posedge clk); #1;
    reset = 1'b0;
    wait_init();
    chk("pend_busy", init_busy, 0);
    chk("pend_gnt_first", gnt, 0);
    @(posedge clk); #1;
    chk("pend_gnt", gnt, 3'b010);
    chk("pend_addr", mem_addr, 45);
    chk("pend_we", mem_we, 0);
    clear_req();
    @(posedge clk); #1;
    chk("pend_rvalid", rvalid, 3'b010);

`ifdef MAP_ARB_INIT_EN
    // Reset partway through the fill must restart it from address 0.
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    repeat (20) @(posedge clk);
    #1;
    chk("midinit_busy", init_busy, 1);
    do_reset();
`endif

    // Directed single-access vectors.
    do_reset();
    for (int i = 0; i < 13; i++) run_vec(i, vecs[i]);

    // All three requesters held: grants rotate 0,1,2 with no gaps.
    do_reset();
    req    = 3'b111;
    req_we = 3'b000;
    req_x  = {5'd5, 5'd2, 5'd1};
    req_y  = {5'd3, 5'd1, 5'd0};
    for (int k = 0; k < 6; k++) begin
      @(posedge clk); #1;
      g = k % 3;
      chk($sformatf("rr%0d_gnt", k), gnt, 3'b001 << g);
      chk($sformatf("rr%0d_addr", k), mem_addr, caddr[g]);
      chk($sformatf("rr%0d_we", k), mem_we, 0);
      if (k > 0) chk($sformatf("rr%0d_rvalid", k), rvalid, 3'b001 << ((k - 1) % 3));
    end
    clear_req();
    @(posedge clk); #1;
    chk("rr_end_gnt", gnt, 0);
    chk("rr_end_rvalid", rvalid, 3'b100);

    // Reset one cycle after a read grant discards the read.
    do_reset();
    drive_one(1, 1'b0, 5'd3, 5'd2, 3'd0);
    @(posedge clk); #1;
    chk("r28_gnt", gnt, 3'b010);
    clear_req();
    @(posedge clk); #1;
    reset = 1'b1;
    #1;
    chk("r28_rvalid", rvalid, 0);
    chk("r28_rdata", rdata, 0);
    @(posedge clk); #1;
    check_zero("r28_after");
    reset = 1'b0;
    @(posedge clk); #1;
    chk("r28_rvalid_late", rvalid, 0);
    wait_init();

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1);
  end

endmodule
